// File: rtl/fxp_pkg.sv
// Shared constants and helpers for the fixed-point multiplier datapath.
package fxp_pkg;

  // Rounding modes; the remaining encoding (3) falls back to truncation.
  localparam logic [1:0] RND_TRUNC     = 2'd0;
  localparam logic [1:0] RND_HALF_UP   = 2'd1;
  localparam logic [1:0] RND_HALF_EVEN = 2'd2;

  // Largest value representable in a signed field of out_bits bits.
  function automatic longint sat_max(input int out_bits);
    return (longint'(1) <<< (out_bits - 1)) - longint'(1);
  endfunction

  // Smallest value representable in a signed field of out_bits bits.
  function automatic longint sat_min(input int out_bits);
    return -(longint'(1) <<< (out_bits - 1));
  endfunction

endpackage

// File: rtl/fxp_round_sat.sv
// Combinational rounding and saturation of one full-width product lane.
module fxp_round_sat
  import fxp_pkg::*;
#(
  parameter int BITSIZE   = 14,
  parameter int FRAC_BITS = 7,
  parameter int OUT_BITS  = 14
) (
  input  logic signed [2*BITSIZE-1:0] product,
  input  logic        [1:0]           mode,
  output logic signed [OUT_BITS-1:0]  result,
  output logic                        sat
);

  localparam int PW = 2 * BITSIZE;
  // One spare bit above the shifted product so the round-up increment cannot wrap.
  localparam int RW = PW - FRAC_BITS + 1;

  localparam logic [FRAC_BITS-1:0] HALF  = FRAC_BITS'(1 << (FRAC_BITS - 1));
  localparam logic signed [RW-1:0] MAX_R = RW'(sat_max(OUT_BITS));
  localparam logic signed [RW-1:0] MIN_R = RW'(sat_min(OUT_BITS));

  logic signed [RW-1:0]    trunc_val;
  logic signed [RW-1:0]    rounded;
  logic [FRAC_BITS-1:0]    frac;
  logic                    round_up;

  assign trunc_val = RW'(product >>> FRAC_BITS);
  assign frac      = product[FRAC_BITS-1:0];

  // Decide whether the discarded fraction bumps the floor value up by one.
  always_comb begin
    round_up = 1'b0;
    case (mode)
      RND_HALF_UP:   round_up = (frac >= HALF);
      RND_HALF_EVEN: round_up = (frac > HALF) || ((frac == HALF) && trunc_val[0]);
      default:       round_up = 1'b0;
    endcase
  end

  assign rounded = trunc_val + RW'(round_up);

  // Clamp the rounded value into the signed output range and flag clipping.
  always_comb begin
    result = rounded[OUT_BITS-1:0];
    sat    = 1'b0;
    if (rounded > MAX_R) begin
      result = MAX_R[OUT_BITS-1:0];
      sat    = 1'b1;
    end else if (rounded < MIN_R) begin
      result = MIN_R[OUT_BITS-1:0];
      sat    = 1'b1;
    end
  end

endmodule

// File: rtl/fixed_point_mul_pipe.sv
// Multi-lane signed fixed-point multiplier: product stage, round/saturate stage,
// valid/ready handshake with stalls propagating straight back to the input.
module fixed_point_mul_pipe
  import fxp_pkg::*;
#(
  parameter int BITSIZE   = 14,
  parameter int FRAC_BITS = 7,
  parameter int OUT_BITS  = 14,
  parameter int LANES     = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [LANES*BITSIZE-1:0]    in_a,
  input  logic [LANES*BITSIZE-1:0]    in_b,
  input  logic [1:0]                  round_mode,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [LANES*OUT_BITS-1:0]   out_data,
  output logic [LANES-1:0]            out_sat
);

  localparam int PW = 2 * BITSIZE;

  logic                 v1;
  logic                 v2;
  logic                 en1;
  logic                 en2;
  logic [1:0]           mode_s1;
  logic signed [PW-1:0] prod_c  [LANES];
  logic signed [PW-1:0] prod_s1 [LANES];
  logic [LANES*OUT_BITS-1:0] rs_data;
  logic [LANES-1:0]          rs_sat;

  // A stage may advance when it is empty or the stage after it is advancing.
  assign en2       = !v2 || out_ready;
  assign en1       = !v1 || en2;
  assign in_ready  = en1;
  assign out_valid = v2;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign prod_c[i] = PW'($signed(in_a[i*BITSIZE +: BITSIZE]))
                     * PW'($signed(in_b[i*BITSIZE +: BITSIZE]));

    fxp_round_sat #(
      .BITSIZE  (BITSIZE),
      .FRAC_BITS(FRAC_BITS),
      .OUT_BITS (OUT_BITS)
    ) u_round_sat (
      .product(prod_s1[i]),
      .mode   (mode_s1),
      .result (rs_data[i*OUT_BITS +: OUT_BITS]),
      .sat    (rs_sat[i])
    );
  end

  // First stage: capture full products and the beat's rounding mode.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1      <= 1'b0;
      mode_s1 <= RND_TRUNC;
      for (int i = 0; i < LANES; i++) prod_s1[i] <= '0;
    end else if (en1) begin
      v1 <= in_valid && in_ready;
      if (in_valid) begin
        mode_s1 <= round_mode;
        for (int i = 0; i < LANES; i++) prod_s1[i] <= prod_c[i];
      end
    end
  end

  // Second stage: hold rounded/saturated results until downstream takes them.
  always_ff @(posedge clk) begin
    if (rst) begin
      v2       <= 1'b0;
      out_data <= '0;
      out_sat  <= '0;
    end else if (en2) begin
      v2 <= v1;
      if (v1) begin
        out_data <= rs_data;
        out_sat  <= rs_sat;
      end
    end
  end

endmodule

// File: tb/tb_fixed_point_mul_pipe.sv
// Self-checking bench for fixed_point_mul_pipe with a queue-based scoreboard.
module tb_fixed_point_mul_pipe;

  localparam int BITSIZE     = 14;
  localparam int FRAC_BITS   = 7;
  localparam int OUT_BITS    = 14;
  localparam int LANES       = 4;
  localparam int NUM_BEATS   = 10000;
  localparam int CYCLE_LIMIT = 60000;

  logic                        clk = 1'b0;
  logic                        rst;
  logic                        in_valid;
  logic                        in_ready;
  logic [LANES*BITSIZE-1:0]    in_a;
  logic [LANES*BITSIZE-1:0]    in_b;
  logic [1:0]                  round_mode;
  logic                        out_valid;
  logic                        out_ready;
  logic [LANES*OUT_BITS-1:0]   out_data;
  logic [LANES-1:0]            out_sat;

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct {
    logic [LANES*OUT_BITS-1:0] data;
    logic [LANES-1:0]          sat;
  } exp_t;

  exp_t sb[$];

  fixed_point_mul_pipe #(
    .BITSIZE  (BITSIZE),
    .FRAC_BITS(FRAC_BITS),
    .OUT_BITS (OUT_BITS),
    .LANES    (LANES)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .round_mode(round_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat)
  );

  always #5 clk = ~clk;

  // Reference model for one lane: returns {sat, result}.
  function automatic logic [OUT_BITS:0] model_lane(input logic signed [BITSIZE-1:0] a,
                                                   input logic signed [BITSIZE-1:0] b,
                                                   input logic [1:0] mode);
    longint p, t, f, r, half, maxv, minv;
    bit up;
    p    = longint'(a) * longint'(b);
    t    = p >>> FRAC_BITS;
    f    = p - (t <<< FRAC_BITS);
    half = longint'(1) <<< (FRAC_BITS - 1);
    maxv = (longint'(1) <<< (OUT_BITS - 1)) - 1;
    minv = -(longint'(1) <<< (OUT_BITS - 1));
    up   = 1'b0;
    if (mode == 2'd1) up = (f >= half);
    if (mode == 2'd2) up = (f > half) || ((f == half) && t[0]);
    r = t + longint'(up);
    if (r > maxv) return {1'b1, OUT_BITS'(maxv)};
    if (r < minv) return {1'b1, OUT_BITS'(minv)};
    return {1'b0, OUT_BITS'(r)};
  endfunction

  function automatic exp_t model_beat(input logic [LANES*BITSIZE-1:0] a,
                                      input logic [LANES*BITSIZE-1:0] b,
                                      input logic [1:0] mode);
    exp_t e;
    logic [OUT_BITS:0] l;
    for (int i = 0; i < LANES; i++) begin
      l = model_lane(a[i*BITSIZE +: BITSIZE], b[i*BITSIZE +: BITSIZE], mode);
      e.data[i*OUT_BITS +: OUT_BITS] = l[OUT_BITS-1:0];
      e.sat[i] = l[OUT_BITS];
    end
    return e;
  endfunction

  // Scoreboard: pops on every output transfer, pushes on every input transfer.
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (rst) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        tests_run++;
        if (sb.size() == 0) begin
          tests_failed++;
          $display("[TB] FAIL sb_underflow: got data=%h sat=%b with nothing expected", out_data, out_sat);
        end else begin
          e = sb.pop_front();
          if (out_data !== e.data || out_sat !== e.sat) begin
            tests_failed++;
            $display("[TB] FAIL sb_compare: got data=%h sat=%b, expected data=%h sat=%b",
                     out_data, out_sat, e.data, e.sat);
          end
        end
      end
      if (in_valid && in_ready) sb.push_back(model_beat(in_a, in_b, round_mode));
    end
  end

  task automatic set_lane(input int i, input int a, input int b);
    in_a[i*BITSIZE +: BITSIZE] = BITSIZE'(a);
    in_b[i*BITSIZE +: BITSIZE] = BITSIZE'(b);
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; round_mode = 2'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_sat !== '0 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL reset_state: got valid=%b data=%h sat=%b ready=%b, expected 0/0/0/1",
               out_valid, out_data, out_sat, in_ready);
    end
  endtask

  task automatic test_basic();
    logic [OUT_BITS-1:0] got;
    @(negedge clk);
    out_ready = 1'b1; in_a = '0; in_b = '0; round_mode = 2'd0;
    set_lane(0, 192, 256);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL basic_latency1: out_valid=%b, expected 0", out_valid);
    end
    @(negedge clk); #1;
    got = out_data[0 +: OUT_BITS];
    tests_run++;
    if (out_valid !== 1'b1 || got !== OUT_BITS'(384) || out_sat[0] !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL basic_product: valid=%b lane0=%0d sat=%b, expected 1/384/0",
               out_valid, $signed(got), out_sat[0]);
    end
    @(negedge clk); #1;
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL basic_single_cycle: out_valid=%b, expected 0", out_valid);
    end
  endtask

  task automatic test_ties();
    int exp_tab [4][3];
    logic [OUT_BITS-1:0] got;
    exp_tab = '{'{0, 1, -1}, '{1, 2, 0}, '{0, 2, 0}, '{0, 1, -1}};
    for (int m = 0; m < 4; m++) begin
      @(negedge clk);
      out_ready = 1'b1; in_a = '0; in_b = '0; round_mode = 2'(m);
      set_lane(0, 1, 64); set_lane(1, 3, 64); set_lane(2, -1, 64);
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk); #1;
      for (int l = 0; l < 3; l++) begin
        got = out_data[l*OUT_BITS +: OUT_BITS];
        tests_run++;
        if (out_valid !== 1'b1 || got !== OUT_BITS'(exp_tab[m][l]) || out_sat[l] !== 1'b0) begin
          tests_failed++;
          $display("[TB] FAIL ties_m%0d_l%0d: valid=%b got=%0d sat=%b, expected %0d sat=0",
                   m, l, out_valid, $signed(got), out_sat[l], exp_tab[m][l]);
        end
      end
    end
  endtask

  task automatic test_saturation();
    int exp_v [3];
    logic [2:0] exp_s;
    logic [OUT_BITS-1:0] got;
    exp_v = '{8191, -8192, 63};
    exp_s = 3'b011;
    @(negedge clk);
    out_ready = 1'b1; in_a = '0; in_b = '0; round_mode = 2'd0;
    set_lane(0, 8191, 8191); set_lane(1, -8192, 8191); set_lane(2, 8191, 1);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk); #1;
    for (int l = 0; l < 3; l++) begin
      got = out_data[l*OUT_BITS +: OUT_BITS];
      tests_run++;
      if (out_valid !== 1'b1 || got !== OUT_BITS'(exp_v[l]) || out_sat[l] !== exp_s[l]) begin
        tests_failed++;
        $display("[TB] FAIL sat_l%0d: valid=%b got=%0d sat=%b, expected %0d sat=%b",
                 l, out_valid, $signed(got), out_sat[l], exp_v[l], exp_s[l]);
      end
    end
  endtask

  task automatic test_backpressure();
    int accepted = 0;
    int emerged = 0;
    logic [LANES*OUT_BITS-1:0] held;
    exp_t first;
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      for (int l = 0; l < LANES; l++) set_lane(l, 100 * (k + 1) + l, 130 + 7 * l);
      round_mode = 2'(k);
      in_valid = 1'b1;
      if (k == 0) first = model_beat(in_a, in_b, round_mode);
      #1;
      if (in_ready) accepted++;
      if (k == 2) held = out_data;
    end
    tests_run++;
    if (accepted != 2 || in_ready !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL bp_accept: accepted=%0d in_ready=%b, expected 2/0", accepted, in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    tests_run++;
    if (out_valid !== 1'b1 || out_data !== held || out_data !== first.data) begin
      tests_failed++;
      $display("[TB] FAIL bp_stable: valid=%b data=%h, expected 1/%h", out_valid, out_data, first.data);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      out_ready = 1'b1;
      #1;
      if (out_valid) emerged++;
      if (c == 1) begin
        tests_run++;
        if (emerged != 2) begin
          tests_failed++;
          $display("[TB] FAIL bp_rate: %0d beats in 2 cycles, expected 2", emerged);
        end
      end
    end
    tests_run++;
    if (emerged != 2 || sb.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL bp_drain: emerged=%0d pending=%0d, expected 2/0", emerged, sb.size());
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    @(negedge clk);
    out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      if (k > 0) @(negedge clk);
      for (int l = 0; l < LANES; l++) set_lane(l, 500 + k, 300 - l);
      round_mode = 2'd1;
      in_valid = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    tests_run++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL rstmid_full: valid=%b ready=%b, expected 1/0", out_valid, in_ready);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_sat !== '0 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL rstmid_clear: valid=%b data=%h sat=%b ready=%b, expected 0/0/0/1",
               out_valid, out_data, out_sat, in_ready);
    end
    out_ready = 1'b1;
    for (int l = 0; l < LANES; l++) set_lane(l, -77 * (l + 1), 91);
    round_mode = 2'd2;
    in_valid = 1'b1;
    e = model_beat(in_a, in_b, round_mode);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL rstmid_latency1: out_valid=%b, expected 0", out_valid);
    end
    @(negedge clk); #1;
    tests_run++;
    if (out_valid !== 1'b1 || out_data !== e.data || out_sat !== e.sat) begin
      tests_failed++;
      $display("[TB] FAIL rstmid_after: valid=%b data=%h, expected 1/%h", out_valid, out_data, e.data);
    end
  endtask

  task automatic test_random_stream();
    int accepted = 0;
    int cycles = 0;
    int v;
    while (accepted < NUM_BEATS && cycles < CYCLE_LIMIT) begin
      @(negedge clk);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      round_mode = 2'($urandom_range(0, 3));
      for (int l = 0; l < LANES; l++) begin
        for (int s = 0; s < 2; s++) begin
          case ($urandom_range(0, 7))
            0:       v = 8191;
            1:       v = -8192;
            default: v = int'($urandom_range(0, 16383)) - 8192;
          endcase
          if (s == 0) in_a[l*BITSIZE +: BITSIZE] = BITSIZE'(v);
          else        in_b[l*BITSIZE +: BITSIZE] = BITSIZE'(v);
        end
      end
      #1;
      if (in_valid && in_ready) accepted++;
      cycles++;
    end
    tests_run++;
    if (accepted < NUM_BEATS) begin
      tests_failed++;
      $display("[TB] FAIL stream_timeout: accepted=%0d in %0d cycles, expected %0d", accepted, cycles, NUM_BEATS);
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 20 && (sb.size() != 0 || out_valid); c++) @(negedge clk);
    #3;
    tests_run++;
    if (sb.size() != 0 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL stream_drain: pending=%0d out_valid=%b, expected 0/0", sb.size(), out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ties();
    test_saturation();
    test_backpressure();
    test_reset_mid();
    test_random_stream();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/fixed_point_mul_pipe.md
Name: fixed_point_mul_pipe

Overview:
- Multi-lane, parametrised successor to the single fixed-point multiplier used in the conv/depthwise datapath.
- Each cycle it multiplies LANES pairs of signed Q-format operands and applies a run-time selectable rounding mode.
- Results saturate to a configurable output width and leave through a 2-stage pipeline with valid/ready backpressure.
- Sits between the line-buffer/weight fetch and the accumulator array, so stalls from the accumulator propagate upstream.

Parameters:
- BITSIZE, 14: width of each signed input operand.
- FRAC_BITS, 7: fractional bits of each operand and of the result. Must satisfy 1 <= FRAC_BITS < BITSIZE.
- OUT_BITS, 14: width of each signed result, with FRAC_BITS fractional bits. Must satisfy OUT_BITS <= 2*BITSIZE-FRAC_BITS.
- LANES, 4: number of parallel multiplier lanes.

Ports:
- clk, input, 1: single clock, rising edge.
- rst, input, 1: reset. Synchronous, active-high.
- in_valid, input, 1: input beat valid.
- in_ready, output, 1: block can accept an input beat this cycle.
- in_a, input, LANES*BITSIZE: lane i operand a at [i*BITSIZE +: BITSIZE], signed.
- in_b, input, LANES*BITSIZE: lane i operand b, same packing as in_a.
- round_mode, input, 2: rounding mode, sampled with each input beat.
- out_valid, output, 1: output beat valid.
- out_ready, input, 1: downstream accepts the output beat.
- out_data, output, LANES*OUT_BITS: lane i result at [i*OUT_BITS +: OUT_BITS], signed.
- out_sat, output, LANES: per-lane flag, 1 = the lane result was saturated.

Behaviour:
- Input transfer occurs when in_valid && in_ready. Output transfer occurs when out_valid && out_ready.
- Stage 1 (S1): registers the full products P_i = a_i*b_i (2*BITSIZE bits, signed), the round_mode, and valid v1.
- Stage 2 (S2): registers the rounded and saturated results, the sat flags, and valid v2. out_valid = v2.
- Stage enables: en2 = !v2 || out_ready; en1 = !v1 || en2; in_ready = en1 (combinational, no registered skid).
- When en1 is set: v1 <= in_valid && in_ready, and the S1 data loads only when the input transfers.
- When en2 is set: v2 <= v1, and the S2 data loads only when v1 = 1.
- When a stage enable is low, that stage's valid and data hold unchanged. Data must never be dropped or duplicated.
- Latency: 2 cycles from input transfer to out_valid with no stall. Throughput is 1 beat/cycle while out_ready = 1.
- Rounding operates on P with frac field F = P[FRAC_BITS-1:0] and half point H = 2^(FRAC_BITS-1). T = P >>> FRAC_BITS (arithmetic shift, i.e. floor).
  - mode 0, TRUNC: R = T.
  - mode 1, HALF_UP: R = T + (F >= H), i.e. round toward +inf on ties.
  - mode 2, HALF_EVEN: R = T + ((F > H) || (F == H && T[0])).
  - mode 3: reserved, behaves exactly as TRUNC.
- R is computed at 2*BITSIZE-FRAC_BITS+1 bits so the +1 cannot wrap.
- Saturation:
  - If R > 2^(OUT_BITS-1)-1: output the max value, sat = 1.
  - If R < -2^(OUT_BITS-1): output the min value, sat = 1.
  - Otherwise output R[OUT_BITS-1:0], sat = 0.
- Lanes are fully independent. All lanes share one valid and one mode.
- Reset (rst = 1 at a clock edge): v1, v2, the S1/S2 data, out_data and out_sat all go to 0. out_valid = 0 after that edge. In-flight beats are discarded, including a reset arriving mid-stall.
- in_ready during reset follows the en1 equation using the cleared valids, so it reads 1 after the reset edge. Upstream must not send beats while rst = 1; any beat presented is discarded.
- Simultaneous input and output transfer while full: allowed; the pipeline shifts by one.
- out_data and out_sat must stay stable while out_valid && !out_ready.

Decomposition:
- Package fxp_pkg holds:
  - rounding-mode constants RND_TRUNC = 2'd0, RND_HALF_UP = 2'd1, RND_HALF_EVEN = 2'd2;
  - a function for the saturation limits from OUT_BITS.
- One combinational sub-module, fxp_round_sat (product, mode -> result, sat), generated LANES times between S1 and S2.

Test Plan (BITSIZE=14, FRAC_BITS=7, OUT_BITS=14, LANES=4):
- Basic product: lane0 a=192 (1.5), b=256 (2.0), mode 0, out_ready=1 -> 2 cycles later out_data lane0 = 384 (3.0), sat=0, out_valid high for exactly 1 cycle.
- Ties: lane0 a=1, b=64 (P=64); lane1 a=3, b=64 (P=192); lane2 a=-1, b=64 (P=-64).
  - mode 0 -> 0, 1, -1.
  - mode 1 -> 1, 2, 0.
  - mode 2 -> 0, 2, 0.
- Saturation: a=8191, b=8191 -> 8191, sat=1. a=-8192, b=8191 -> -8192, sat=1. a=8191, b=1 -> 63, sat=0. All within one beat across lanes.
- Backpressure:
  - Hold out_ready=0 and offer 4 consecutive beats -> exactly 2 accepted, then in_ready=0, and out_data stays stable on the first beat.
  - Raise out_ready -> all beats emerge in order, none lost or duplicated, 1/cycle.
- Reset mid-operation: with v1 = v2 = 1 and out_ready=0, pulse rst for 1 cycle -> out_valid=0, out_data=0, out_sat=0 next cycle, in_ready=1. A later beat emerges with normal 2-cycle latency.
- Random streaming: 10k beats, random operands, modes 0-3, random in_valid/out_ready -> compare every lane against a reference model. Mode 3 must match mode 0.
